tdc_hit_decoder: RTL
====================

// Module: tdc_hit_decoder
// PURPOSE
//  Consumer side of the fine delay line. Takes the Start/Stop thermometer words captured on hit
//  rise/fall, decodes each to a fine count, and measures the whole clock cycles between them
//  (coarse). Emits one pulse-width record per hit through a small FIFO with a valid/ready output.
//  Sits between the fine-delay/edge-detect stage and the readout logic, in the iClk domain.
// PARAMETERS
//  NUM_TAPS    120  taps per thermometer word (one delay line)
//  FINE_W      7    fine count width, >= clog2(NUM_TAPS+1)
//  COARSE_W    12   coarse counter width
//  FIFO_DEPTH  4    output record FIFO depth, power of 2
// PORTS
//  iClk        in   1                    system clock
//  iRst_n      in   1                    asynchronous reset, active-low
//  iStartValid in   1                    1-cycle strobe: iStartTaps holds a captured rise
//  iStartTaps  in   NUM_TAPS             Start column FF outputs, bit0 = first tap
//  iStopValid  in   1                    1-cycle strobe: iStopTaps holds a captured fall
//  iStopTaps   in   NUM_TAPS             Stop column FF outputs
//  oValid      out  1                    record available at FIFO head
//  iReady      in   1                    consumer accepts record when oValid & iReady
//  oCoarse     out  COARSE_W             cycles from start strobe to stop strobe
//  oFineStart  out  FINE_W               decoded start fine count
//  oFineStop   out  FINE_W               decoded stop fine count
//  oWidth      out  COARSE_W+FINE_W+1    coarse*NUM_TAPS + fineStart - fineStop, clamped at 0
//  oTimeout    out  1                    record flag: stop never arrived, coarse saturated
//  oDropCnt    out  8                    records lost to a full FIFO, saturates at 255
// BEHAVIOUR
//  Reset: FSM IDLE, counter 0, FIFO empty, oValid=0, all data outputs 0, oDropCnt=0.
//   Reset is honoured in any state. A pending hit and all FIFO contents are discarded.
//  Fine decode: fine = popcount(taps), range 0..NUM_TAPS. Ones-count makes decode bubble-tolerant.
//   The decode is a 2-stage pipeline. Start and stop words use identical decoders.
//  FSM:
//   IDLE: iStartValid -> WAIT_STOP, coarse counter cleared to 0, start word captured.
//     iStopValid alone is ignored.
//   WAIT_STOP: the counter increments each cycle.
//     iStopValid at k cycles after the start strobe -> coarse=k, record issued, state -> IDLE.
//     iStartValid is ignored in this state: the first start wins.
//     Counter reaching 2^COARSE_W-1 with no stop -> record issued with oTimeout=1,
//       fineStop=0, coarse=all ones, oWidth=0; state -> IDLE.
//   iStartValid & iStopValid in the same cycle in IDLE -> record with coarse=0, state stays IDLE.
//   iStopValid & iStartValid in the same cycle in WAIT_STOP -> the stop closes the current hit.
//     The start is ignored.
//  Width: computed at full precision in the pipeline.
//   A negative result is clamped to 0. This is only possible when coarse=0.
//  Latency: a stop strobe in cycle T writes the FIFO at the end of T+2.
//   With the FIFO empty, oValid=1 in cycle T+3.
//  FIFO: first-word fall-through, head stable while oValid & !iReady.
//   Write while full drops the new record and increments oDropCnt, saturating at 255.
//   Simultaneous pop and push when full: the pop frees space, so the push succeeds.
//   Pointers wrap modulo FIFO_DEPTH.
//   Back-to-back hits are supported: a new start may arrive the cycle after a stop.
// TESTING
//  1 Start taps = 40 ones, stop 3 cycles later with 10 ones -> coarse=3, fS=40, fP=10, W=390, T+3 valid.
//  2 Start and stop in the same cycle, fS=50, fP=20 -> coarse=0, W=30. Same cycle fS=5, fP=20 -> W=0.
//  3 Start with no stop, COARSE_W=4 -> after 15 cycles record oTimeout=1, coarse=15, W=0, FSM IDLE.
//  4 Bubble word 0b...0001011 (3 ones) -> fine=3. All-ones -> 120. All-zeros -> 0.
//  5 iReady=0, 6 hits -> 4 records held in order, oDropCnt=2. Then iReady=1 drains 4, oValid falls.
//  6 iRst_n low in WAIT_STOP with FIFO holding 2 -> oValid=0, FIFO empty. A later stop alone is ignored.

Source files
------------

// File: rtl/tdc_hit_decoder.sv
// Start/Stop thermometer decoder with a coarse cycle counter.
// Emits one pulse-width record per hit through a small first-word fall-through FIFO.
module tdc_hit_decoder #(
    parameter int NUM_TAPS   = 120,
    parameter int FINE_W     = 7,
    parameter int COARSE_W   = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         iClk,
    input  logic                         iRst_n,
    input  logic                         iStartValid,
    input  logic [NUM_TAPS-1:0]          iStartTaps,
    input  logic                         iStopValid,
    input  logic [NUM_TAPS-1:0]          iStopTaps,
    output logic                         oValid,
    input  logic                         iReady,
    output logic [COARSE_W-1:0]          oCoarse,
    output logic [FINE_W-1:0]            oFineStart,
    output logic [FINE_W-1:0]            oFineStop,
    output logic [COARSE_W+FINE_W:0]     oWidth,
    output logic                         oTimeout,
    output logic [7:0]                   oDropCnt
);

    localparam int WIDTH_W = COARSE_W + FINE_W + 1;
    localparam int CALC_W  = WIDTH_W + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int REC_W   = 1 + COARSE_W + 2 * FINE_W + WIDTH_W;

    typedef enum logic {
        IDLE,
        WAIT_STOP
    } state_t;

    state_t                state;
    logic [COARSE_W-1:0]   coarseCnt;
    logic [COARSE_W-1:0]   elapsed;
    logic [NUM_TAPS-1:0]   startWord;

    logic                  s1Valid;
    logic                  s1Timeout;
    logic [COARSE_W-1:0]   s1Coarse;
    logic [NUM_TAPS-1:0]   s1StartTaps;
    logic [NUM_TAPS-1:0]   s1StopTaps;

    logic                  s2Valid;
    logic                  s2Timeout;
    logic [COARSE_W-1:0]   s2Coarse;
    logic [FINE_W-1:0]     s2FineStart;
    logic [FINE_W-1:0]     s2FineStop;

    logic [WIDTH_W-1:0]    scaledCoarse;
    logic signed [CALC_W-1:0] rawWidth;
    logic [WIDTH_W-1:0]    clampWidth;
    logic [REC_W-1:0]      newRecord;

    logic [REC_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W:0]        wrPtr;
    logic [PTR_W:0]        rdPtr;
    logic [7:0]            dropCnt;
    logic                  fifoEmpty;
    logic                  fifoFull;
    logic                  doPop;
    logic                  doPush;

    // Ones-count decode tolerates bubbles in the thermometer word.
    function automatic logic [FINE_W-1:0] popCount(input logic [NUM_TAPS-1:0] taps);
        logic [FINE_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            sum = sum + FINE_W'(taps[i]);
        end
        return sum;
    endfunction

    assign elapsed = coarseCnt + COARSE_W'(1);

    // Hit FSM and first pipeline stage: the first start wins, a stop or a
    // saturated counter closes the hit and hands the raw words to the decoder.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state       <= IDLE;
            coarseCnt   <= '0;
            startWord   <= '0;
            s1Valid     <= 1'b0;
            s1Timeout   <= 1'b0;
            s1Coarse    <= '0;
            s1StartTaps <= '0;
            s1StopTaps  <= '0;
        end else begin
            s1Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStartValid && iStopValid) begin
                        s1Valid     <= 1'b1;
                        s1Timeout   <= 1'b0;
                        s1Coarse    <= '0;
                        s1StartTaps <= iStartTaps;
                        s1StopTaps  <= iStopTaps;
                    end else if (iStartValid) begin
                        state     <= WAIT_STOP;
                        coarseCnt <= '0;
                        startWord <= iStartTaps;
                    end
                end
                WAIT_STOP: begin
                    if (iStopValid) begin
                        s1Valid     <= 1'b1;
                        s1Timeout   <= 1'b0;
                        s1Coarse    <= elapsed;
                        s1StartTaps <= startWord;
                        s1StopTaps  <= iStopTaps;
                        state       <= IDLE;
                    end else if (elapsed == '1) begin
                        s1Valid     <= 1'b1;
                        s1Timeout   <= 1'b1;
                        s1Coarse    <= elapsed;
                        s1StartTaps <= startWord;
                        s1StopTaps  <= '0;
                        state       <= IDLE;
                    end else begin
                        coarseCnt <= elapsed;
                    end
                end
            endcase
        end
    end

    // Second pipeline stage: fine counts for both words.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            s2Valid     <= 1'b0;
            s2Timeout   <= 1'b0;
            s2Coarse    <= '0;
            s2FineStart <= '0;
            s2FineStop  <= '0;
        end else begin
            s2Valid     <= s1Valid;
            s2Timeout   <= s1Timeout;
            s2Coarse    <= s1Coarse;
            s2FineStart <= popCount(s1StartTaps);
            s2FineStop  <= popCount(s1StopTaps);
        end
    end

    // One extra bit of headroom keeps the subtraction signed; only coarse=0 can go negative.
    always_comb begin
        scaledCoarse = WIDTH_W'(s2Coarse) * WIDTH_W'(NUM_TAPS);
        rawWidth     = $signed({1'b0, scaledCoarse})
                     + $signed(CALC_W'(s2FineStart))
                     - $signed(CALC_W'(s2FineStop));
        clampWidth   = '0;
        if (!s2Timeout && rawWidth >= 0) begin
            clampWidth = rawWidth[WIDTH_W-1:0];
        end
        newRecord = {s2Timeout, s2Coarse, s2FineStart, s2FineStop, clampWidth};
    end

    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                       (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
    assign doPop     = !fifoEmpty && iReady;
    assign doPush    = s2Valid && (!fifoFull || doPop);

    // Record FIFO: a pop in the same cycle frees the slot for a push into a full FIFO.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            dropCnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem[wrPtr[PTR_W-1:0]] <= newRecord;
                wrPtr <= wrPtr + (PTR_W+1)'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + (PTR_W+1)'(1);
            end
            if (s2Valid && !doPush && dropCnt != 8'hFF) begin
                dropCnt <= dropCnt + 8'd1;
            end
        end
    end

    assign oValid   = !fifoEmpty;
    assign oDropCnt = dropCnt;
    assign {oTimeout, oCoarse, oFineStart, oFineStop, oWidth} = mem[rdPtr[PTR_W-1:0]];

endmodule
